// File: rtl/matmul_pkg.sv
// matmul_pkg
//   Shared declarations for the matrix multiply sequencer:
//   - seq_state_t : sequencer FSM states (IDLE, RUN, WRITE, DONE)
//   - acc_width() : accumulator width that holds a full-precision sum of
//                   'acolumns' products of two width_bit signed operands
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // 2*W bits for one product, plus enough guard bits for K additions.
    function automatic int acc_width(input int width_bit, input int acolumns);
        return 2 * width_bit + $clog2(acolumns + 1);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// mac_unit
//   Signed multiply-accumulate with a full-precision product and no
//   saturation.
//   Ports:
//     clock, reset : rising-edge clock, synchronous active-high reset
//     clr          : start a fresh sum (with en) or zero the sum (without en)
//     en           : accumulate a*b this cycle
//     a, b         : signed operands, WIDTH_BIT each
//     acc          : signed running sum, ACC_W bits
module mac_unit #(
    parameter int WIDTH_BIT = 32,
    parameter int ACC_W     = 66
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [WIDTH_BIT-1:0] a,
    input  logic signed [WIDTH_BIT-1:0] b,
    output logic signed [ACC_W-1:0]     acc
);

    localparam int PROD_W = 2 * WIDTH_BIT;

    // Sign-extend the exact product into the accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_prod(
        input logic signed [PROD_W-1:0] p
    );
        return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;

    assign prod     = a * b;
    assign prod_ext = sext_prod(prod);

    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= (clr ? '0 : acc) + prod_ext;
        end else if (clr) begin
            acc <= '0;
        end
    end

endmodule

// File: rtl/matrix_mult_sequencer.sv
// matrix_mult_sequencer
//   Computes C = A * B by walking the indices i (row of C), j (column of C)
//   and k (inner dimension) against an external matrix access memory that
//   returns A[i][k] and B[k][j] in the same cycle. Each C element takes
//   ACOLUMNS RUN cycles followed by one WRITE cycle; elements come out in
//   row-major order, followed by a one-cycle DONE.
//   Ports:
//     clock, reset      : rising-edge clock, synchronous active-high reset
//     start             : one-cycle request to begin (ignored while busy)
//     Aik, Bkj          : signed operands from the access memory
//     i, j, k           : indices to the access memory
//     ena               : access enable, high only in RUN
//     busy              : high in any state other than IDLE
//     done              : one-cycle completion pulse
//     c_valid           : c_row / c_col / c_data valid this cycle
//     c_row, c_col      : coordinates of the C element
//     c_data            : C element value, ACC_W bits signed
module matrix_mult_sequencer
    import matmul_pkg::*;
#(
    parameter int AROWS     = 3,
    parameter int ACOLUMNS  = 3,
    parameter int BCOLUMNS  = 3,
    parameter int WIDTH_BIT = 32,
    localparam int ACC_W    = acc_width(WIDTH_BIT, ACOLUMNS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic signed [WIDTH_BIT-1:0] Aik,
    input  logic signed [WIDTH_BIT-1:0] Bkj,
    output logic [WIDTH_BIT-1:0]        i,
    output logic [WIDTH_BIT-1:0]        j,
    output logic [WIDTH_BIT-1:0]        k,
    output logic                        ena,
    output logic                        busy,
    output logic                        done,
    output logic                        c_valid,
    output logic [WIDTH_BIT-1:0]        c_row,
    output logic [WIDTH_BIT-1:0]        c_col,
    output logic signed [ACC_W-1:0]     c_data
);

    localparam logic [WIDTH_BIT-1:0] I_LAST = WIDTH_BIT'(AROWS - 1);
    localparam logic [WIDTH_BIT-1:0] J_LAST = WIDTH_BIT'(BCOLUMNS - 1);
    localparam logic [WIDTH_BIT-1:0] K_LAST = WIDTH_BIT'(ACOLUMNS - 1);

    seq_state_t              state;
    logic                    mac_en;
    logic                    mac_clr;
    logic signed [ACC_W-1:0] acc;

    // The first product of each element overwrites the sum; the sum is also
    // zeroed when a new multiply is accepted from IDLE.
    assign mac_en  = (state == RUN);
    assign mac_clr = (state == RUN) ? (k == '0) : ((state == IDLE) && start);

    mac_unit #(
        .WIDTH_BIT (WIDTH_BIT),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clock (clock),
        .reset (reset),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (Aik),
        .b     (Bkj),
        .acc   (acc)
    );

    // Indices hold through WRITE, so they name the element being written.
    assign c_row  = i;
    assign c_col  = j;
    assign c_data = acc;

    // Outputs are registered together with the state so each one matches
    // the state it belongs to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            ena     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            c_valid <= 1'b0;
        end else begin
            done    <= 1'b0;
            c_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        ena   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (k == K_LAST) begin
                        state   <= WRITE;
                        ena     <= 1'b0;
                        c_valid <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                WRITE: begin
                    if (j < J_LAST) begin
                        j     <= j + 1'b1;
                        k     <= '0;
                        state <= RUN;
                        ena   <= 1'b1;
                    end else if (i < I_LAST) begin
                        i     <= i + 1'b1;
                        j     <= '0;
                        k     <= '0;
                        state <= RUN;
                        ena   <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ena   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// tb_matrix_mult_sequencer
//   Directed bench with four sequencer instances sharing one clock:
//     u2 : 2x2x2, 32-bit   A=[[1,2],[3,4]], B=I
//     u3 : 3x3x3, 32-bit   signed example, restart / reset-mid-run cases
//     u8 : 3x3x3, 8-bit    all operands -128
//     u1 : 1x1x1, 32-bit   A=5, B=-6
//   Cycle 1 is the first cycle after the edge that samples start.
module tb_matrix_mult_sequencer;

    typedef logic signed [65:0] acc_t;
    typedef struct {
        int   r;
        int   c;
        acc_t d;
        int   cy;
    } wr_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vecs = 0;
    int errs = 0;

    // ---------------- u2 : 2x2 ----------------
    logic               rst2, st2, ena2, busy2, done2, cv2;
    logic [31:0]        i2, j2, k2, row2, col2;
    logic signed [31:0] a2, b2;
    logic signed [65:0] dat2;
    int A2 [2][2] = '{'{1, 2}, '{3, 4}};
    int B2 [2][2] = '{'{1, 0}, '{0, 1}};
    assign a2 = A2[i2[0]][k2[0]];
    assign b2 = B2[k2[0]][j2[0]];

    matrix_mult_sequencer #(.AROWS(2), .ACOLUMNS(2), .BCOLUMNS(2), .WIDTH_BIT(32)) u2 (
        .clock(clock), .reset(rst2), .start(st2), .Aik(a2), .Bkj(b2),
        .i(i2), .j(j2), .k(k2), .ena(ena2), .busy(busy2), .done(done2),
        .c_valid(cv2), .c_row(row2), .c_col(col2), .c_data(dat2)
    );

    // ---------------- u3 : 3x3 signed ----------------
    logic               rst3, st3, ena3, busy3, done3, cv3;
    logic [31:0]        i3, j3, k3, row3, col3;
    logic signed [31:0] a3, b3;
    logic signed [65:0] dat3;
    int A3 [3][3] = '{'{-1, 2, 0}, '{3, -4, 5}, '{0, 0, 7}};
    int B3 [3][3] = '{'{2, 0, 1}, '{1, -1, 0}, '{0, 3, -2}};
    assign a3 = A3[i3[1:0]][k3[1:0]];
    assign b3 = B3[k3[1:0]][j3[1:0]];

    matrix_mult_sequencer #(.AROWS(3), .ACOLUMNS(3), .BCOLUMNS(3), .WIDTH_BIT(32)) u3 (
        .clock(clock), .reset(rst3), .start(st3), .Aik(a3), .Bkj(b3),
        .i(i3), .j(j3), .k(k3), .ena(ena3), .busy(busy3), .done(done3),
        .c_valid(cv3), .c_row(row3), .c_col(col3), .c_data(dat3)
    );

    // ---------------- u8 : 3x3 8-bit, all -128 ----------------
    logic               rst8, st8, ena8, busy8, done8, cv8;
    logic [7:0]         i8, j8, k8, row8, col8;
    logic signed [7:0]  a8, b8;
    logic signed [17:0] dat8;
    assign a8 = 8'sh80;
    assign b8 = 8'sh80;

    matrix_mult_sequencer #(.AROWS(3), .ACOLUMNS(3), .BCOLUMNS(3), .WIDTH_BIT(8)) u8 (
        .clock(clock), .reset(rst8), .start(st8), .Aik(a8), .Bkj(b8),
        .i(i8), .j(j8), .k(k8), .ena(ena8), .busy(busy8), .done(done8),
        .c_valid(cv8), .c_row(row8), .c_col(col8), .c_data(dat8)
    );

    // ---------------- u1 : 1x1x1 ----------------
    logic               rst1, st1, ena1, busy1, done1, cv1;
    logic [31:0]        i1, j1, k1, row1, col1;
    logic signed [31:0] a1, b1;
    logic signed [64:0] dat1;
    assign a1 = 32'sd5;
    assign b1 = -32'sd6;

    matrix_mult_sequencer #(.AROWS(1), .ACOLUMNS(1), .BCOLUMNS(1), .WIDTH_BIT(32)) u1 (
        .clock(clock), .reset(rst1), .start(st1), .Aik(a1), .Bkj(b1),
        .i(i1), .j(j1), .k(k1), .ena(ena1), .busy(busy1), .done(done1),
        .c_valid(cv1), .c_row(row1), .c_col(col1), .c_data(dat1)
    );

    // ---------------- output monitors ----------------
    int  base2 = 0, base3 = 0, base8 = 0, base1 = 0;
    int  dn2 = 0, dn3 = 0, dn8 = 0, dn1 = 0;
    int  dc2 = 0, dc3 = 0, dc8 = 0, dc1 = 0;
    wr_t q2[$], q3[$], q8[$], q1[$];

    always @(negedge clock) begin
        if (cv2) q2.push_back('{r: int'(row2), c: int'(col2), d: acc_t'(dat2), cy: cyc - base2 + 1});
        if (cv3) q3.push_back('{r: int'(row3), c: int'(col3), d: acc_t'(dat3), cy: cyc - base3 + 1});
        if (cv8) q8.push_back('{r: int'(row8), c: int'(col8), d: acc_t'(dat8), cy: cyc - base8 + 1});
        if (cv1) q1.push_back('{r: int'(row1), c: int'(col1), d: acc_t'(dat1), cy: cyc - base1 + 1});
        if (done2) begin dn2++; dc2 = cyc - base2 + 1; end
        if (done3) begin dn3++; dc3 = cyc - base3 + 1; end
        if (done8) begin dn8++; dc8 = cyc - base8 + 1; end
        if (done1) begin dn1++; dc1 = cyc - base1 + 1; end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input acc_t obs, input acc_t exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Element x of a row-major result is written in cycle per*(x+1).
    task automatic chk_seq(input string tag, input wr_t q[$], input int n,
                           input int cols, input int per, input acc_t e[9]);
        chk({tag, "_count"}, q.size(), n);
        for (int x = 0; x < q.size() && x < n; x++) begin
            chk($sformatf("%s_row%0d", tag, x), q[x].r, x / cols);
            chk($sformatf("%s_col%0d", tag, x), q[x].c, x % cols);
            chk($sformatf("%s_data%0d", tag, x), q[x].d, e[x]);
            chk($sformatf("%s_cyc%0d", tag, x), q[x].cy, per * (x + 1));
        end
    endtask

    acc_t e2[9] = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    acc_t e3[9] = '{0, -2, -1, 2, 19, -7, 0, 21, -14};
    acc_t e8[9] = '{49152, 49152, 49152, 49152, 49152, 49152, 49152, 49152, 49152};
    acc_t e1[9] = '{-30, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        rst2 = 1'b1; rst3 = 1'b1; rst8 = 1'b1; rst1 = 1'b1;
        st2 = 1'b0;  st3 = 1'b0;  st8 = 1'b0;  st1 = 1'b0;
        repeat (3) @(negedge clock);

        // reset state
        chk("rst_busy",  busy3, 0);
        chk("rst_ena",   ena3, 0);
        chk("rst_done",  done3, 0);
        chk("rst_cv",    cv3, 0);
        chk("rst_i",     i3, 0);
        chk("rst_j",     j3, 0);
        chk("rst_k",     k3, 0);
        chk("rst_cdata", dat3, 0);
        rst2 = 1'b0; rst3 = 1'b0; rst8 = 1'b0;
        @(negedge clock);

        // 2x2 times identity
        q2.delete(); dn2 = 0;
        st2 = 1'b1; @(negedge clock); st2 = 1'b0; base2 = cyc;
        chk("m2_busy_c1", busy2, 1);
        chk("m2_ena_c1",  ena2, 1);
        repeat (16) @(negedge clock);
        chk_seq("m2", q2, 4, 2, 3, e2);
        chk("m2_done_n",   dn2, 1);
        chk("m2_done_cyc", dc2, 13);
        chk("m2_idle_busy", busy2, 0);
        chk("m2_idle_ena",  ena2, 0);
        chk("m2_hold_i", i2, 1);
        chk("m2_hold_j", j2, 1);
        chk("m2_hold_k", k2, 1);

        // 3x3 signed
        q3.delete(); dn3 = 0;
        st3 = 1'b1; @(negedge clock); st3 = 1'b0; base3 = cyc;
        chk("m3_ena_c1", ena3, 1);
        chk("m3_k_c1",   k3, 0);
        @(negedge clock);
        chk("m3_k_c2",   k3, 1);
        repeat (2) @(negedge clock);
        chk("m3_ena_wr", ena3, 0);
        chk("m3_cv_wr",  cv3, 1);
        repeat (37) @(negedge clock);
        chk_seq("m3", q3, 9, 3, 4, e3);
        chk("m3_done_n",   dn3, 1);
        chk("m3_done_cyc", dc3, 37);

        // start re-asserted in RUN (cycle 5) and in DONE (cycle 37)
        q3.delete(); dn3 = 0;
        st3 = 1'b1; @(negedge clock); st3 = 1'b0; base3 = cyc;
        for (int c = 1; c <= 44; c++) begin
            st3 = (c == 5 || c == 37);
            if (c == 40) chk("rs_busy_after", busy3, 0);
            @(negedge clock);
        end
        st3 = 1'b0;
        chk_seq("rs", q3, 9, 3, 4, e3);
        chk("rs_done_n",   dn3, 1);
        chk("rs_done_cyc", dc3, 37);

        // reset in WRITE of element (1,1), i.e. cycle 20
        q3.delete(); dn3 = 0;
        st3 = 1'b1; @(negedge clock); st3 = 1'b0; base3 = cyc;
        repeat (19) @(negedge clock);
        chk("mr_cv_w11",  cv3, 1);
        chk("mr_row_w11", row3, 1);
        chk("mr_col_w11", col3, 1);
        chk("mr_dat_w11", dat3, 19);
        rst3 = 1'b1;
        @(negedge clock);
        chk("mr_busy",  busy3, 0);
        chk("mr_cv",    cv3, 0);
        chk("mr_cdata", dat3, 0);
        chk("mr_ena",   ena3, 0);
        chk("mr_done",  done3, 0);
        chk("mr_i", i3, 0);
        chk("mr_j", j3, 0);
        chk("mr_k", k3, 0);
        rst3 = 1'b0;
        repeat (10) @(negedge clock);
        chk("mr_no_partial", q3.size(), 5);
        chk("mr_no_done",    dn3, 0);
        q3.delete(); dn3 = 0;
        st3 = 1'b1; @(negedge clock); st3 = 1'b0; base3 = cyc;
        repeat (40) @(negedge clock);
        chk_seq("mr_rerun", q3, 9, 3, 4, e3);
        chk("mr_rerun_done_cyc", dc3, 37);

        // 8-bit, all operands -128: sum of three 16384 products
        q8.delete(); dn8 = 0;
        st8 = 1'b1; @(negedge clock); st8 = 1'b0; base8 = cyc;
        repeat (40) @(negedge clock);
        chk_seq("w8", q8, 9, 3, 4, e8);
        chk("w8_done_cyc", dc8, 37);

        // reset wins over start on u1 (still held in reset)
        st1 = 1'b1; @(negedge clock); st1 = 1'b0;
        chk("pri_busy", busy1, 0);
        chk("pri_ena",  ena1, 0);
        rst1 = 1'b0;
        @(negedge clock);
        chk("pri_busy2", busy1, 0);

        // 1x1x1
        q1.delete(); dn1 = 0;
        st1 = 1'b1; @(negedge clock); st1 = 1'b0; base1 = cyc;
        repeat (6) @(negedge clock);
        chk_seq("m1", q1, 1, 1, 2, e1);
        chk("m1_done_n",   dn1, 1);
        chk("m1_done_cyc", dc1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
